// File: rtl/ipf_pkg.sv
// Shared definitions for the in-loop pixel filter front end: frame geometry,
// LCU size codes, feeder state encoding and the size-to-dimension helper.
package ipf_pkg;

  localparam int IMG_W = 128;

  localparam logic [1:0] LCU16 = 2'd0;
  localparam logic [1:0] LCU32 = 2'd1;
  localparam logic [1:0] LCU64 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE
  } feeder_state_t;

  // Code 3 has no LCU of its own; it behaves as the largest size.
  function automatic logic [1:0] clamp_size(input logic [1:0] size);
    return (size == 2'd3) ? LCU64 : size;
  endfunction

  function automatic logic [7:0] lcu_dim(input logic [1:0] size);
    return 8'd16 << clamp_size(size);
  endfunction

endpackage

// File: rtl/ipf_lcu_feeder_if.sv
// Bus between the LCU feeder, the image memory and the pixel filter.
interface ipf_lcu_feeder_if #(
  parameter int IMG_W = ipf_pkg::IMG_W
);
  localparam int AW = 2 * $clog2(IMG_W);

  // Handshake: img_data is sampled on the clock edge that closes a cycle with
  // img_rd high, so din/in_en present that pixel in the following cycle; the
  // filter accepts a pixel on every edge with in_en high, and the feeder only
  // raises in_en after seeing busy rise and fall once per burst.
  logic          img_rd;
  logic [AW-1:0] img_addr;
  logic [7:0]    img_data;
  logic          busy;
  logic          in_en;
  logic [7:0]    din;
  logic [2:0]    lcu_x;
  logic [2:0]    lcu_y;
  logic [1:0]    lcu_size;

  modport master (
    output img_rd, img_addr, in_en, din, lcu_x, lcu_y, lcu_size,
    input  img_data, busy
  );

  modport slave (
    input  img_rd, img_addr, in_en, din, lcu_x, lcu_y, lcu_size,
    output img_data, busy
  );

endinterface

// File: rtl/ipf_lcu_feeder.sv
// Streams a frame from image memory into the pixel filter LCU by LCU, one
// burst at a time, pausing for a full busy high/low cycle after each burst.
module ipf_lcu_feeder #(
  parameter int IMG_W = ipf_pkg::IMG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            cfg_lcu_size,
  output logic                  active,
  output logic                  frame_done,
  output ipf_pkg::feeder_state_t fsm_state,
  ipf_lcu_feeder_if.master      bus
);
  import ipf_pkg::*;

  localparam int LW  = $clog2(IMG_W);
  localparam int AW  = 2 * LW;
  localparam int AW1 = AW + 1;

  feeder_state_t state_q, state_d;
  logic [1:0]    size_q;
  logic [2:0]    x_q, y_q;
  logic [6:0]    r_q, c_q;
  logic          in_en_q;
  logic [7:0]    din_q;

  logic [7:0]     n;
  logic [7:0]     n_m1;
  logic [2:0]     lcu_max;
  logic           issue;
  logic           last_issue;
  logic           rows_left;
  logic           lcu_last;
  logic           accept;
  logic           adv_lcu;
  logic [AW1-1:0] row_abs;
  logic [AW1-1:0] col_abs;
  logic [AW1-1:0] addr_full;

  assign n       = lcu_dim(size_q);
  assign n_m1    = n - 8'd1;
  assign lcu_max = 3'((IMG_W >> (4 + int'(size_q))) - 1);
  assign issue   = (state_q == ST_ISSUE);

  // The first burst of an LCU spans rows 0..2, later ones a single row, so a
  // burst ends at the end of any row from row 2 onward.
  assign last_issue = ({1'b0, c_q} == n_m1) && (r_q >= 7'd2);
  assign rows_left  = ({1'b0, r_q} < n);
  assign lcu_last   = (x_q == lcu_max) && (y_q == lcu_max);

  assign row_abs   = AW1'(y_q) * AW1'(n) + AW1'(r_q);
  assign col_abs   = AW1'(x_q) * AW1'(n) + AW1'(c_q);
  assign addr_full = (row_abs << LW) + col_abs;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    adv_lcu = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          accept  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (bus.busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!bus.busy) begin
          if (rows_left) begin
            state_d = ST_ISSUE;
          end else if (!lcu_last) begin
            state_d = ST_ISSUE;
            adv_lcu = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      size_q  <= 2'd0;
      x_q     <= 3'd0;
      y_q     <= 3'd0;
      r_q     <= 7'd0;
      c_q     <= 7'd0;
      in_en_q <= 1'b0;
      din_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      in_en_q <= issue;
      if (issue) din_q <= bus.img_data;

      if (accept) begin
        size_q <= clamp_size(cfg_lcu_size);
        x_q    <= 3'd0;
        y_q    <= 3'd0;
        r_q    <= 7'd0;
        c_q    <= 7'd0;
      end else if (adv_lcu) begin
        r_q <= 7'd0;
        c_q <= 7'd0;
        if (x_q == lcu_max) begin
          x_q <= 3'd0;
          y_q <= y_q + 3'd1;
        end else begin
          x_q <= x_q + 3'd1;
        end
      end else if (issue) begin
        if ({1'b0, c_q} == n_m1) begin
          c_q <= 7'd0;
          r_q <= r_q + 7'd1;
        end else begin
          c_q <= c_q + 7'd1;
        end
      end
    end
  end

  // Address is forced to zero outside ISSUE so the bus is quiet when idle.
  assign bus.img_rd   = issue;
  assign bus.img_addr = issue ? AW'(addr_full) : '0;
  assign bus.in_en    = in_en_q;
  assign bus.din      = din_q;
  assign bus.lcu_x    = x_q;
  assign bus.lcu_y    = y_q;
  assign bus.lcu_size = size_q;

  assign active     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign frame_done = (state_q == ST_DONE);
  assign fsm_state  = state_q;

endmodule
